// File: rtl/aes_ctr_engine.sv
// aes_ctr_engine: ECB/CTR mode sequencer for an external iterative AES-128 core.
// It accepts one 128-bit block at a time on a valid/ready port and runs it
// through the core using the start/done handshake. In CTR mode the keystream
// is XORed into the data. Results are queued in a small output FIFO.
module aes_ctr_engine #(
  parameter int CTR_WIDTH  = 32,  // low-order counter bits that increment (8..128)
  parameter int FIFO_DEPTH = 4    // output FIFO entries, power of two (2..16)
) (
  input  logic         clk,
  input  logic         rst_n,       // asynchronous, active-high despite the name
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         cfg_mode,    // 0 = ECB, 1 = CTR
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         core_start,
  output logic [127:0] core_block,
  output logic [127:0] core_key,
  input  logic [127:0] core_result,
  input  logic         core_done,
  output logic         busy,
  output logic         ctr_wrap
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  // Selects the incrementing low field of the counter block. A width of 128
  // gives a shift of zero, so the whole block counts.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [127:0]       r_key;
  logic [127:0]       r_ctr;
  logic               r_mode;
  logic               r_wrap;
  logic [127:0]       r_data_hold;
  logic [127:0]       r_result;
  logic               r_out_of_reset;

  logic [127:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_done_take;
  logic               w_cfg_take;
  logic [127:0]       w_ctr_inc;
  logic [127:0]       w_ctr_next;
  logic               w_ctr_wraps;

  // Handshake qualifiers shared by the FSM and the datapath.
  assign w_accept    = in_valid && in_ready;
  assign w_push      = (r_state == S_STORE);
  assign w_pop       = out_valid && out_ready;
  assign w_done_take = (r_state == S_WAIT) && core_done;
  assign w_cfg_take  = (r_state == S_IDLE) && cfg_load;

  // Counter step: only the low CTR_WIDTH bits advance, upper bits are kept.
  assign w_ctr_inc   = r_ctr + 128'd1;
  assign w_ctr_next  = (r_ctr & ~CTR_MASK) | (w_ctr_inc & CTR_MASK);
  assign w_ctr_wraps = ((w_ctr_inc & CTR_MASK) == 128'd0);

  // State register; reset drops any in-flight block immediately.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the FSM-decoded outputs.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    core_start   = 1'b0;
    busy         = 1'b1;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = r_out_of_reset && (r_count < DEPTH_C) && !cfg_load;
        if (in_valid && in_ready) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        core_start   = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          w_state_next = S_STORE;
        end
      end
      S_STORE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Holds in_ready low while reset is asserted and releases it one edge later.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_out_of_reset <= 1'b0;
    end else begin
      r_out_of_reset <= 1'b1;
    end
  end

  // Configuration and counter: loaded in IDLE, counter advances on CTR stores.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_key  <= 128'd0;
      r_ctr  <= 128'd0;
      r_mode <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_cfg_take) begin
      r_key  <= cfg_key;
      r_ctr  <= cfg_iv;
      r_mode <= cfg_mode;
      r_wrap <= 1'b0;
    end else if (w_push && r_mode) begin
      r_ctr <= w_ctr_next;
      if (w_ctr_wraps) begin
        r_wrap <= 1'b1;
      end
    end
  end

  // Input block capture on acceptance.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_data_hold <= 128'd0;
    end else if (w_accept) begin
      r_data_hold <= in_data;
    end
  end

  // Result capture at core_done; in CTR mode the core output is keystream.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_result <= 128'd0;
    end else if (w_done_take) begin
      r_result <= r_mode ? (core_result ^ r_data_hold) : core_result;
    end
  end

  // FIFO storage, written on the STORE cycle.
  // NOTE: the storage is reset so out_data reads zero after reset; at most
  // 16 entries, so the reset fan-out stays modest.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 128'd0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= r_result;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign core_block = r_mode ? r_ctr : r_data_hold;
  assign core_key   = r_key;
  assign ctr_wrap   = r_wrap;

endmodule

// File: doc/aes_ctr_engine.md
# aes_ctr_engine

Block-level mode sequencer that streams 128-bit blocks through an external iterative AES-128 core using its start/done handshake. It supports ECB and CTR modes. In CTR mode it keeps a parametrised-width block counter and XORs the keystream into the data. It adds valid/ready stream ports and an output FIFO, so the core can sit inside a streaming datapath instead of being driven one block at a time from a bench.

## Interface
- CTR_WIDTH, 32: number of low-order bits of the 128-bit counter block that increment; legal range 8–128.
- FIFO_DEPTH, 4: output FIFO entries; a power of two, 2–16.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-high. rst_n=1 resets the block.
- cfg_load  in  1  loads cfg_key, cfg_iv and cfg_mode; honoured only in IDLE.
- cfg_key  in  128  AES-128 key.
- cfg_iv  in  128  initial counter block.
- cfg_mode  in  1  0=ECB, 1=CTR.
- in_valid / in_ready  in / out  1 / 1  input handshake.
- in_data  in  128  plaintext block.
- out_valid / out_ready  out / in  1 / 1  output handshake.
- out_data  out  128  result block (FIFO head).
- core_start  out  1  one-cycle start pulse to the AES core.
- core_block  out  128  block presented to the core, stable from core_start until core_done.
- core_key  out  128  registered key, equal to the loaded cfg_key.
- core_result  in  128  core output, valid while core_done=1.
- core_done  in  1  core completion pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- ctr_wrap  out  1  sticky flag, set when the counter field wraps to zero; cleared by reset or cfg_load.

## Operation
- **Registers:** key, ctr (128-bit), mode, data_hold (128), FSM state, FIFO storage with a count.
- **FSM states and transitions:**
  - IDLE: on in_valid&in_ready, capture in_data into data_hold, go to START.
  - START: core_start=1 for exactly this cycle, go to WAIT.
  - WAIT: on core_done, go to STORE.
  - STORE: push the result into the FIFO, go to IDLE.
- **Core block:** core_block = ctr in CTR mode, data_hold in ECB mode.
- **Stored result:** CTR mode stores core_result ^ data_hold; ECB mode stores core_result. The result is latched at core_done in WAIT and written in STORE.
- **Counter update:** CTR mode only, on the STORE cycle, ctr[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH.
  - ctr[127:CTR_WIDTH] never changes.
  - If the incremented field equals 0, ctr_wrap is set.
  - ECB mode never touches ctr.
- **in_ready:** in_ready = (state==IDLE) && (count < FIFO_DEPTH) && !cfg_load. At most one block is in flight.
- **Configuration loading:** cfg_load in IDLE loads key←cfg_key, ctr←cfg_iv, mode←cfg_mode, and clears ctr_wrap. cfg_load in any other state is ignored entirely.
- **FIFO:**
  - out_valid = (count != 0).
  - A pop occurs on out_valid&out_ready.
  - A push and a pop in the same cycle leave count unchanged; order is strictly FIFO.
  - A push never happens when count==FIFO_DEPTH, because entry to START already required free space.
- **Stray core_done:** core_done outside WAIT is ignored.
- **Reset mid-operation:** asserting rst_n in any state discards the in-flight block and all FIFO contents. The state returns to IDLE immediately (asynchronously).
- **Reset values:**
  - in_ready=0 while reset is asserted, then 1 in the first cycle after release.
  - out_valid=0, out_data=0, core_start=0, core_block=0, core_key=0, busy=0, ctr_wrap=0.
  - Internal ctr=0, mode=ECB.

## Timing
- **Input to core:** input accepted at edge T. core_start=1 in cycle T+1. The core sees core_block stable from T+1.
- **Core to output:** core_done=1 in cycle D. STORE occurs in cycle D+1. out_valid=1 from edge D+2 if the FIFO was previously empty.
- **Latency and throughput:**
  - Input-accept to out_valid latency = core latency + 3 cycles.
  - Minimum input interval = core latency + 3 cycles.
- **Output handshake:** out_data changes only on a pop or on a push into an empty FIFO. It is held stable while out_valid&!out_ready.
- **Configuration timing:** cfg_load takes effect at the next edge. A block accepted in the same cycle is impossible, because in_ready is low while cfg_load=1.

## Test plan
1. **ECB FIPS-197 vector.** Bench core model is a real AES-128.
   - Stimulus: cfg_mode=0, key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff.
   - Required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a, one core_start pulse, latency = core latency + 3.
2. **CTR keystream.**
   - Stimulus: cfg_mode=1, iv 000…0000, same key, two blocks of all zeros.
   - Required: outputs equal AES(key, 0…00) and AES(key, 0…01); core_block observed as 0…00 then 0…01.
3. **Counter wrap.**
   - Stimulus: CTR_WIDTH=8, iv 11111111111111111111111111111fff, two blocks.
   - Required: second core_block = 11111111111111111111111111111f00, ctr_wrap=1 after the first STORE.
4. **Backpressure.**
   - Stimulus: FIFO_DEPTH=4, out_ready=0, offer 6 blocks.
   - Required: exactly 4 accepted, then in_ready=0. After out_ready=1, all 6 emerge in input order with no drops or duplicates.
5. **cfg_load while busy.**
   - Stimulus: cfg_load with a new key during WAIT.
   - Required: ignored, core_key unchanged. The same cfg_load in IDLE updates core_key and clears ctr_wrap.
6. **Reset mid-block.**
   - Stimulus: assert rst_n during WAIT with 2 FIFO entries.
   - Required: busy=0 and out_valid=0 asynchronously. A late core_done is ignored. The next block after release completes normally.
